// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types, reset constants and condition-code helper for reg_file
package reg_file_pkg;

   localparam int DEF_WIDTH    = 16;
   localparam int DEF_NUM_REGS = 8;

   typedef struct packed {
      logic n;
      logic z;
      logic p;
   } nzp_t;

   localparam nzp_t NZP_RESET = 3'b010;

   // word is zero-extended by the caller; msb selects the sign bit of the real width
   function automatic nzp_t cc_of(input logic [63:0] word, input logic [5:0] msb);
      nzp_t cc;
      cc.n = word[msb];
      cc.z = (word == 64'd0);
      cc.p = !cc.n && !cc.z;
      return cc;
   endfunction

endpackage

// File: rtl/reg_word.sv
// rtl/reg_word.sv - single load-enabled data word with synchronous active-low reset
module reg_word #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge Clk) begin
      if (!Reset)
         q <= '0;
      else if (ld)
         q <= d;
   end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - register file with NZP and busy scoreboard; REG_FILE_BYPASS_EN enables write-to-read bypass
module reg_file
   import reg_file_pkg::*;
#(
   parameter  int WIDTH    = DEF_WIDTH,
   parameter  int NUM_REGS = DEF_NUM_REGS,
   localparam int RW       = $clog2(NUM_REGS)
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                ld_reg,
   input  logic [RW-1:0]       dr,
   input  logic [WIDTH-1:0]    bus_in,
   input  logic                ld_cc,
   input  logic [RW-1:0]       sr1,
   input  logic [RW-1:0]       sr2,
   output logic [WIDTH-1:0]    sr1_out,
   output logic [WIDTH-1:0]    sr2_out,
   output logic [2:0]          nzp,
   input  logic                issue,
   input  logic [RW-1:0]       issue_dr,
   output logic [NUM_REGS-1:0] busy,
   output logic                sr1_busy,
   output logic                sr2_busy,
   output logic                sb_err
);

   logic [WIDTH-1:0]    words [NUM_REGS];
   nzp_t                nzp_q;
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_next;
   logic                err_q;
   logic                err_set;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
      reg_word #(.WIDTH(WIDTH)) u_word (
         .Clk   (Clk),
         .Reset (Reset),
         .ld    (ld_reg && (dr == RW'(g))),
         .d     (bus_in),
         .q     (words[g])
      );
   end

   always_ff @(posedge Clk) begin
      if (!Reset)
         nzp_q <= NZP_RESET;
      else if (ld_cc)
         nzp_q <= cc_of(64'(bus_in), 6'(WIDTH - 1));
   end

   // retire first so a same-index issue overrides it
   always_comb begin
      busy_next = busy_q;
      if (ld_reg)
         busy_next[dr] = 1'b0;
      if (issue)
         busy_next[issue_dr] = 1'b1;
      err_set = issue && busy_q[issue_dr] && !(ld_reg && (dr == issue_dr));
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_next;
         if (err_set)
            err_q <= 1'b1;
      end
   end

   assign nzp    = nzp_q;
   assign busy   = busy_q;
   assign sb_err = err_q;

`ifdef REG_FILE_BYPASS_EN
   logic hit1, hit2, reissue;

   always_comb begin
      hit1     = ld_reg && (sr1 == dr);
      hit2     = ld_reg && (sr2 == dr);
      reissue  = issue && (issue_dr == dr);
      sr1_out  = hit1 ? bus_in  : words[sr1];
      sr2_out  = hit2 ? bus_in  : words[sr2];
      sr1_busy = hit1 ? reissue : busy_q[sr1];
      sr2_busy = hit2 ? reissue : busy_q[sr2];
   end
`else
   always_comb begin
      sr1_out  = words[sr1];
      sr2_out  = words[sr2];
      sr1_busy = busy_q[sr1];
      sr2_busy = busy_q[sr2];
   end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - table-driven self-checking bench for reg_file
module tb_reg_file;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        ld_reg;
   logic [2:0]  dr;
   logic [15:0] bus_in;
   logic        ld_cc;
   logic [2:0]  sr1, sr2;
   logic [15:0] sr1_out, sr2_out;
   logic [2:0]  nzp;
   logic        issue;
   logic [2:0]  issue_dr;
   logic [7:0]  busy;
   logic        sr1_busy, sr2_busy;
   logic        sb_err;

   int errors = 0;
   int checks = 0;

   always #5 Clk = ~Clk;

   reg_file dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .ld_reg   (ld_reg),
      .dr       (dr),
      .bus_in   (bus_in),
      .ld_cc    (ld_cc),
      .sr1      (sr1),
      .sr2      (sr2),
      .sr1_out  (sr1_out),
      .sr2_out  (sr2_out),
      .nzp      (nzp),
      .issue    (issue),
      .issue_dr (issue_dr),
      .busy     (busy),
      .sr1_busy (sr1_busy),
      .sr2_busy (sr2_busy),
      .sb_err   (sb_err)
   );

   typedef struct {
      logic        rst_n;
      logic        ld_reg;
      logic [2:0]  dr;
      logic [15:0] bus;
      logic        ld_cc;
      logic        issue;
      logic [2:0]  issue_dr;
      logic [2:0]  sr1;
      logic [2:0]  sr2;
      logic [15:0] e_sr1;
      logic [15:0] e_sr2;
      logic [2:0]  e_nzp;
      logic [7:0]  e_busy;
      logic        e_err;
      logic        e_b1;
      logic        e_b2;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_ctrl();
      Reset  = 1'b1;
      ld_reg = 1'b0;
      ld_cc  = 1'b0;
      issue  = 1'b0;
   endtask

   task automatic check_state(input string tag, input vec_t v);
      chk({tag, ".sr1_out"},  32'(sr1_out),  32'(v.e_sr1));
      chk({tag, ".sr2_out"},  32'(sr2_out),  32'(v.e_sr2));
      chk({tag, ".nzp"},      32'(nzp),      32'(v.e_nzp));
      chk({tag, ".busy"},     32'(busy),     32'(v.e_busy));
      chk({tag, ".sb_err"},   32'(sb_err),   32'(v.e_err));
      chk({tag, ".sr1_busy"}, 32'(sr1_busy), 32'(v.e_b1));
      chk({tag, ".sr2_busy"}, 32'(sr2_busy), 32'(v.e_b2));
   endtask

   initial begin
      //             rst   ld    dr    bus        cc    iss   idr   sr1   sr2   e_sr1      e_sr2      nzp      busy   err   b1    b2
      vecs[0]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0, 3'd7, 16'h0000, 16'h0000, 3'b010, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 3'd3, 16'hBEEF, 1'b1, 1'b0, 3'd0, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 3'b100, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 3'b010, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 3'd2, 16'h0001, 1'b1, 1'b0, 3'd0, 3'd2, 3'd3, 16'h0001, 16'hBEEF, 3'b001, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd5, 3'd5, 3'd3, 16'h0000, 16'hBEEF, 3'b001, 8'h20, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 3'd5, 16'h8000, 1'b1, 1'b1, 3'd5, 3'd5, 3'd5, 16'h8000, 16'h8000, 3'b100, 8'h20, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 3'd5, 16'h7FFF, 1'b0, 1'b0, 3'd0, 3'd5, 3'd3, 16'h7FFF, 16'hBEEF, 3'b100, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd2, 3'd2, 3'd5, 16'h0001, 16'h7FFF, 3'b100, 8'h04, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 3'd2, 16'h0042, 1'b0, 1'b1, 3'd6, 3'd2, 3'd6, 16'h0042, 16'h0000, 3'b100, 8'h40, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd2, 3'd2, 3'd6, 16'h0042, 16'h0000, 3'b100, 8'h44, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd2, 3'd2, 3'd6, 16'h0042, 16'h0000, 3'b100, 8'h44, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 3'd2, 16'h0001, 1'b0, 1'b0, 3'd0, 3'd2, 3'd6, 16'h0001, 16'h0000, 3'b100, 8'h40, 1'b1, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b1, 3'd1, 16'hFFFF, 1'b1, 1'b1, 3'd1, 3'd1, 3'd3, 16'h0000, 16'h0000, 3'b010, 8'h00, 1'b0, 1'b0, 1'b0};

      Reset = 1'b0; ld_reg = 1'b0; dr = '0; bus_in = '0; ld_cc = 1'b0;
      sr1 = '0; sr2 = '0; issue = 1'b0; issue_dr = '0;
      repeat (2) @(posedge Clk);
      #1 idle_ctrl();

      for (int i = 0; i < 13; i++) begin
         Reset    = vecs[i].rst_n;
         ld_reg   = vecs[i].ld_reg;
         dr       = vecs[i].dr;
         bus_in   = vecs[i].bus;
         ld_cc    = vecs[i].ld_cc;
         issue    = vecs[i].issue;
         issue_dr = vecs[i].issue_dr;
         sr1      = vecs[i].sr1;
         sr2      = vecs[i].sr2;
         @(posedge Clk);
         #1 idle_ctrl();
         #1 check_state($sformatf("v%0d", i), vecs[i]);
      end

      // same-cycle write to a busy register read on both ports
      issue = 1'b1; issue_dr = 3'd7;
      @(posedge Clk);
      #1 idle_ctrl();
      ld_reg = 1'b1; dr = 3'd7; bus_in = 16'h1234; sr1 = 3'd7; sr2 = 3'd7;
      #2;
`ifdef REG_FILE_BYPASS_EN
      chk("byp.sr1_out",  32'(sr1_out),  32'h1234);
      chk("byp.sr2_out",  32'(sr2_out),  32'h1234);
      chk("byp.sr1_busy", 32'(sr1_busy), 32'h0);
`else
      chk("byp.sr1_out",  32'(sr1_out),  32'h0000);
      chk("byp.sr2_out",  32'(sr2_out),  32'h0000);
      chk("byp.sr1_busy", 32'(sr1_busy), 32'h1);
`endif
      chk("byp.busy_pre", 32'(busy), 32'h80);
      @(posedge Clk);
      #1 idle_ctrl();
      #1;
      chk("byp.sr1_next",  32'(sr1_out), 32'h1234);
      chk("byp.sr2_next",  32'(sr2_out), 32'h1234);
      chk("byp.busy_next", 32'(busy),    32'h00);

      // double issue raises sb_err, which holds through idle cycles
      issue = 1'b1; issue_dr = 3'd2;
      repeat (2) @(posedge Clk);
      #1 idle_ctrl();
      repeat (3) @(posedge Clk);
      #1 chk("err.hold", 32'(sb_err), 32'h1);
      chk("err.busy", 32'(busy), 32'h04);
      Reset = 1'b0;
      @(posedge Clk);
      #1 idle_ctrl();
      #1 chk("err.reset", 32'(sb_err), 32'h0);
      chk("err.rst_busy", 32'(busy), 32'h00);
      sr1 = 3'd7;
      #1 chk("err.rst_reg7", 32'(sr1_out), 32'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised general-purpose register file for the SLC-3 datapath, replacing the per-register 16-bit load registers with one block. It holds NUM_REGS words of WIDTH bits with one synchronous write port (DR) and two combinational read ports (SR1, SR2). It also holds the NZP condition-code register, derived from the written bus value. A busy-bit scoreboard lets the control FSM track registers with a write still outstanding.

## Interface
Parameters:
- WIDTH, 16, data word width
- NUM_REGS, 8, number of registers (power of two, ≥2)
- RW, $clog2(NUM_REGS), register index width (derived, not overridden)

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-low reset
- ld_reg  in  1  write enable for register dr
- dr  in  RW  destination index
- bus_in  in  WIDTH  write data
- ld_cc  in  1  update NZP from bus_in
- sr1, sr2  in  RW  read indices
- sr1_out, sr2_out  out  WIDTH  read data
- nzp  out  3  condition codes {N,Z,P}
- issue  in  1  mark register issue_dr busy
- issue_dr  in  RW  index being issued
- busy  out  NUM_REGS  per-register busy bits
- sr1_busy, sr2_busy  out  1  busy state of sr1/sr2
- sb_err  out  1  sticky scoreboard error

## Operation
- Reset (Reset=0 at a rising edge) forces the following values, with priority over every other input:
  - all registers 0
  - nzp = 3'b010
  - busy = 0
  - sb_err = 0
- Write: ld_reg=1 at an edge loads bus_in into reg[dr] and clears busy[dr] (retire).
- CC: ld_cc=1 at an edge loads nzp from bus_in, independent of ld_reg:
  - N = bus_in[WIDTH-1]
  - Z = (bus_in == 0)
  - P = otherwise
  - Exactly one bit is ever set.
- Issue: issue=1 at an edge sets busy[issue_dr].
- Issue and retire of the same index in one cycle: issue wins, so the bit stays 1.
- Issue and retire of different indices in one cycle: both take effect.
- Issue to an index already busy and not retiring that cycle: busy stays 1 and sb_err sets. sb_err holds until reset.
- Reads: sr1_out = reg[sr1] and sr2_out = reg[sr2], combinationally. sr1 == sr2 is legal.
- sr1_busy = busy[sr1] and sr2_busy = busy[sr2], with bypass adjustment as described under Configuration.

## Timing
- Write latency: 1 cycle. Data is visible on the read ports after the edge; same-cycle visibility requires bypass.
- nzp and busy update on the edge and are registered outputs, with no combinational path from ld_cc or issue.
- Read ports are purely combinational from the sr indices, register state and (with bypass) ld_reg/dr/bus_in.
- Reset asserted mid-operation discards any simultaneous ld_reg, ld_cc or issue.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - When ld_reg=1 and sr1==dr, sr1_out = bus_in in the same cycle, and sr1_busy = 0 unless issue=1 with issue_dr==dr. The same rule applies to sr2.
- REG_FILE_BYPASS_EN undefined:
  - Reads return the stored value and busy reflects the registered bit only.
  - No combinational path exists from bus_in to sr*_out.

## Structure
- Package reg_file_pkg holds:
  - default WIDTH and NUM_REGS constants
  - typedef nzp_t (packed 3-bit struct n,z,p)
  - NZP_RESET = 3'b010
  - function cc_of(word) returning nzp_t
- Sub-module reg_word: a WIDTH-bit register with synchronous active-low reset and load enable. It is instantiated NUM_REGS times via generate.

## Test plan
- Release reset, then read all indices → every sr*_out = 0, nzp = 010, busy = 0, sb_err = 0.
- ld_reg=1, dr=3, bus_in=16'hBEEF, ld_cc=1 → next cycle with sr1=3: sr1_out = BEEF and nzp = 100. Then bus_in=0 with ld_cc=1 → nzp = 010. Then bus_in=16'h0001 with ld_cc=1 → nzp = 001.
- issue=1, issue_dr=5 → busy = 8'b0010_0000. In the same cycle, ld_reg=1, dr=5 and issue_dr=5 → busy[5] stays 1. Next cycle, ld_reg only → busy[5] = 0 and sb_err = 0.
- issue_dr=2 on two consecutive cycles with no retire → sb_err = 1, and it holds until Reset=0.
- Same-cycle read: ld_reg=1, dr=7, bus_in=16'h1234, sr1=sr2=7, old reg[7]=0 → sr1_out = sr2_out = 1234 with bypass, 0000 without. Both builds show 1234 on the next cycle.
- Reset=0 asserted together with ld_reg=1, dr=1, bus_in=16'hFFFF and issue=1 → after the edge reg[1] = 0, busy = 0 and nzp = 010.
